// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : IDLE / RUN / FLUSH sequencing states
//   fetch_entry_t : one buffered instruction together with its PC
//   word_align()  : clears the byte offset of an address
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int          OPCODE_W  = 7;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's memory, redirect and decode channels.
//   master : fetch unit side (drives imem requests and dec_* outputs)
//   slave  : environment side (memory, execute redirect, decode stage)
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [31:0]         imem_req_addr;
  logic                imem_rsp_valid;
  logic [31:0]         imem_rsp_data;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                dec_valid;
  logic                dec_ready;
  logic [31:0]         dec_instr;
  logic [31:0]         dec_pc;
  logic [OPCODE_W-1:0] dec_opcode;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_pc, dec_opcode,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, dec_opcode,
    output dec_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t. DEPTH must be a power of two >= 2.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   push, push_data     : write an entry (ignored when full without a pop)
//   pop                 : remove the head entry (ignored when empty)
//   flush               : discard all entries; takes priority over push/pop
//   head                : current head entry
//   full, empty, count  : occupancy status
// ----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  entries_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = entries_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) entries_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the fetch PC, issues word requests to instruction
// memory, buffers returned words with their PC and hands them to decode.
// Execute redirects flush the buffer and drop in-flight responses.
//
// Parameters:
//   RESET_PC   : fetch PC after reset
//   FIFO_DEPTH : buffer entries (power of two, >= 2); also caps the number
//                of outstanding memory requests
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : instr_fetch_unit_if.master (imem req/rsp, redirect, dec)
//
// Build option IFU_BYPASS_EN: when defined, a response arriving while the
// buffer is empty (RUN, no redirect) is forwarded combinationally to dec_*
// and only buffered if decode does not take it that cycle.
//
// state | meaning
// IDLE  | one cycle after reset, nothing issued
// RUN   | issuing requests, buffering responses
// FLUSH | dropping responses that were in flight at a redirect
// ----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              redirect;
  logic              credit_ok;
  logic              req_valid;
  logic              req_fire;
  logic              rsp_taken;
  logic [CNT_W-1:0]  outst_after_rsp;
  logic              bypass;
  logic              bypass_take;

  logic              fifo_push;
  logic              fifo_pop;
  fetch_entry_t      fifo_wdata;
  fetch_entry_t      fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign redirect = bus.redirect_valid;

  // A stray response with nothing outstanding (e.g. after a reset the memory
  // did not see) is ignored rather than underflowing the counter.
  assign rsp_taken       = bus.imem_rsp_valid & (outstanding_q != '0);
  assign outst_after_rsp = outstanding_q - CNT_W'(rsp_taken);

  // Credits count both buffered and in-flight words so a response can
  // always be accepted without backpressure.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_L;
  assign req_valid = (state_q == RUN) & credit_ok & ~redirect;
  assign req_fire  = req_valid & bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = word_align(fetch_pc_q);

`ifdef IFU_BYPASS_EN
  assign bypass      = fifo_empty & (state_q == RUN) & rsp_taken & ~redirect;
  assign bypass_take = bypass & bus.dec_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign fifo_push  = (state_q == RUN) & rsp_taken & ~redirect & ~bypass_take;
  assign fifo_pop   = ~fifo_empty & bus.dec_ready;
  assign fifo_wdata = '{instr: bus.imem_rsp_data, pc: rsp_pc_q};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Decode-side view: buffer head, or the live response when bypassing.
  // An idle decode input sees a NOP so a stray sample is harmless.
  always_comb begin
    bus.dec_valid = ~fifo_empty;
    bus.dec_instr = fifo_empty ? INSTR_NOP : fifo_head.instr;
    bus.dec_pc    = fifo_head.pc;
    if (bypass) begin
      bus.dec_valid = 1'b1;
      bus.dec_instr = bus.imem_rsp_data;
      bus.dec_pc    = rsp_pc_q;
    end
  end

  assign bus.dec_opcode = bus.dec_instr[OPCODE_W-1:0];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outst_after_rsp + CNT_W'(req_fire);

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Whatever is still in flight after this cycle must be dropped.
          drop_cnt_d = outst_after_rsp;
          state_d    = (outst_after_rsp != '0) ? FLUSH : RUN;
        end else if (rsp_taken) begin
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
      FLUSH: begin
        if (rsp_taken) drop_cnt_d = drop_cnt_q - 1'b1;
        if (drop_cnt_d == '0) state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect always retargets both PCs; in FLUSH it leaves the drop
    // count alone because the same words are still in flight.
    if (redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      rsp_pc_d   = word_align(bus.redirect_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= word_align(RESET_PC);
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule
